// File: rtl/acc_write_arbiter.sv
// Write-port arbiter for the two 16-bit accumulators (ACC_A, ACC_B).
// Three requesters get independent round-robin arbitration per destination; all outputs are registered.
module acc_write_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dest,
  input  logic [WIDTH-1:0]   data0,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  output logic [NUM_REQ-1:0] gnt,
  output logic               write_signal_a,
  output logic [WIDTH-1:0]   input_value_a,
  output logic               write_signal_b,
  output logic [WIDTH-1:0]   input_value_b
);

  localparam int unsigned PTR_W = 2;

  logic [NUM_REQ-1:0] r_gnt;
  logic               r_wr_a;
  logic               r_wr_b;
  logic [WIDTH-1:0]   r_val_a;
  logic [WIDTH-1:0]   r_val_b;
  logic [PTR_W-1:0]   r_ptr_a;
  logic [PTR_W-1:0]   r_ptr_b;

  logic [NUM_REQ-1:0] w_elig_a;
  logic [NUM_REQ-1:0] w_elig_b;
  logic [NUM_REQ-1:0] w_win_a;
  logic [NUM_REQ-1:0] w_win_b;
  logic [WIDTH-1:0]   w_data_a;
  logic [WIDTH-1:0]   w_data_b;
  logic [PTR_W-1:0]   w_ptr_a_nxt;
  logic [PTR_W-1:0]   w_ptr_b_nxt;

  // First eligible requester scanning ptr, ptr+1, ptr+2 (mod 3); one-hot result.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                  input logic [PTR_W-1:0]   ptr);
    logic [2:0] s;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = 3'(ptr) + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (!found && elig[s[1:0]]) begin
        rr_pick[s[1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
  endfunction

  // Pointer moves to the requester just after the winner.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_REQ-1:0] win);
    ptr_after = '0;
    if (win[0]) ptr_after = PTR_W'(1);
    if (win[1]) ptr_after = PTR_W'(2);
    if (win[2]) ptr_after = PTR_W'(0);
  endfunction

  function automatic logic [WIDTH-1:0] sel_data(input logic [NUM_REQ-1:0] win,
                                                input logic [WIDTH-1:0]   d0,
                                                input logic [WIDTH-1:0]   d1,
                                                input logic [WIDTH-1:0]   d2);
    sel_data = '0;
    if (win[0]) sel_data = d0;
    if (win[1]) sel_data = d1;
    if (win[2]) sel_data = d2;
  endfunction

  // A requester whose grant is currently showing is masked to prevent a double grant.
  always_comb begin
    w_elig_a    = req & ~dest & ~r_gnt;
    w_elig_b    = req &  dest & ~r_gnt;
    w_win_a     = rr_pick(w_elig_a, r_ptr_a);
    w_win_b     = rr_pick(w_elig_b, r_ptr_b);
    w_data_a    = sel_data(w_win_a, data0, data1, data2);
    w_data_b    = sel_data(w_win_b, data0, data1, data2);
    w_ptr_a_nxt = ptr_after(w_win_a);
    w_ptr_b_nxt = ptr_after(w_win_b);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gnt   <= '0;
      r_wr_a  <= 1'b0;
      r_wr_b  <= 1'b0;
      r_val_a <= '0;
      r_val_b <= '0;
      r_ptr_a <= '0;
      r_ptr_b <= '0;
    end else begin
      r_gnt  <= w_win_a | w_win_b;
      r_wr_a <= |w_win_a;
      r_wr_b <= |w_win_b;
      // Data and pointer hold when a destination has no winner.
      if (|w_win_a) begin
        r_val_a <= w_data_a;
        r_ptr_a <= w_ptr_a_nxt;
      end
      if (|w_win_b) begin
        r_val_b <= w_data_b;
        r_ptr_b <= w_ptr_b_nxt;
      end
    end
  end

  assign gnt            = r_gnt;
  assign write_signal_a = r_wr_a;
  assign input_value_a  = r_val_a;
  assign write_signal_b = r_wr_b;
  assign input_value_b  = r_val_b;

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Scoreboard bench for acc_write_arbiter: directed vectors push tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs and an ACC_A register model.
module tb_acc_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  req = 3'b111;
  logic [2:0]  dest = 3'b000;
  logic [15:0] data0 = 16'h0;
  logic [15:0] data1 = 16'h0;
  logic [15:0] data2 = 16'h0;
  logic [2:0]  gnt;
  logic        write_signal_a;
  logic [15:0] input_value_a;
  logic        write_signal_b;
  logic [15:0] input_value_b;

  acc_write_arbiter #(.WIDTH(16), .NUM_REQ(3)) dut (
    .CLK(CLK), .RST(RST), .req(req), .dest(dest),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt),
    .write_signal_a(write_signal_a), .input_value_a(input_value_a),
    .write_signal_b(write_signal_b), .input_value_b(input_value_b)
  );

  always #5 CLK = ~CLK;

  int n_edge = 0;
  always @(posedge CLK) n_edge <= n_edge + 1;

  // ACC_A Register model fed by the arbiter's write port
  logic [15:0] acc_a = 16'h0;
  always @(posedge CLK) begin
    if (RST) acc_a <= 16'h0;
    else if (write_signal_a) acc_a <= input_value_a;
  end

  typedef struct {
    int          tag;
    int          id;
    logic [2:0]  g;
    logic        wa;
    logic [15:0] va;
    logic        wb;
    logic [15:0] vb;
    logic        ca;
    logic [15:0] aa;
  } exp_t;

  exp_t q[$];
  int   vec_id = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  task automatic step(input logic rst, input logic [2:0] rq, input logic [2:0] ds,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                      input logic [2:0] eg, input logic ewa, input logic [15:0] eva,
                      input logic ewb, input logic [15:0] evb,
                      input logic ca, input logic [15:0] aa);
    exp_t e;
    @(posedge CLK);
    #1;
    RST   = rst;
    req   = rq;
    dest  = ds;
    data0 = d0;
    data1 = d1;
    data2 = d2;
    e.tag = n_edge + 1;
    e.id  = vec_id;
    e.g   = eg;
    e.wa  = ewa;
    e.va  = eva;
    e.wb  = ewb;
    e.vb  = evb;
    e.ca  = ca;
    e.aa  = aa;
    vec_id++;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due after the most recent rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].tag <= n_edge) begin
        e = q.pop_front();
        n_vec++;
        if (e.tag < n_edge) begin
          n_bad++;
          $display("FAIL vec%0d: missed, checked at edge %0d, required at edge %0d", e.id, n_edge, e.tag);
        end else if (gnt !== e.g || write_signal_a !== e.wa || input_value_a !== e.va ||
                     write_signal_b !== e.wb || input_value_b !== e.vb ||
                     (e.ca && acc_a !== e.aa)) begin
          n_bad++;
          $display("FAIL vec%0d: got gnt=%b wa=%b va=%h wb=%b vb=%h acc_a=%h, expected gnt=%b wa=%b va=%h wb=%b vb=%h acc_a=%h(chk=%b)",
                   e.id, gnt, write_signal_a, input_value_a, write_signal_b, input_value_b, acc_a,
                   e.g, e.wa, e.va, e.wb, e.vb, e.aa, e.ca);
        end
      end
    end
  end

  initial begin
    // Reset with all requests asserted, then idle
    step(1, 3'b111, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 1, 16'h0);
    step(1, 3'b111, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 1, 16'h0);
    step(0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    // Single write to ACC_A, accumulator captures one edge later
    step(0, 3'b001, 3'b000, 16'hC5A0, 16'h0, 16'h0, 3'b001, 1, 16'hC5A0, 0, 16'h0, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'hC5A0, 16'h0, 16'h0, 3'b000, 0, 16'hC5A0, 0, 16'h0, 1, 16'hC5A0);
    // Parallel writes to both accumulators
    step(0, 3'b101, 3'b100, 16'h1111, 16'h0, 16'hFFFF, 3'b101, 1, 16'h1111, 1, 16'hFFFF, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h1111, 16'h0, 16'hFFFF, 3'b000, 0, 16'h1111, 0, 16'hFFFF, 1, 16'h1111);
    step(1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 1, 16'h0);
    // Three-way contention on ACC_A, two full rotations
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b001, 1, 16'h000A, 0, 16'h0, 0, 16'h0);
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b010, 1, 16'h000B, 0, 16'h0, 0, 16'h0);
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b100, 1, 16'h000C, 0, 16'h0, 0, 16'h0);
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b001, 1, 16'h000A, 0, 16'h0, 0, 16'h0);
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b010, 1, 16'h000B, 0, 16'h0, 0, 16'h0);
    step(0, 3'b111, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b100, 1, 16'h000C, 0, 16'h0, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h000A, 16'h000B, 16'h000C, 3'b000, 0, 16'h000C, 0, 16'h0, 1, 16'h000C);
    // Requester 1 held to ACC_B: grant, masked gap, re-grant
    step(0, 3'b010, 3'b010, 16'h0, 16'h2222, 16'h0, 3'b010, 0, 16'h000C, 1, 16'h2222, 0, 16'h0);
    step(0, 3'b010, 3'b010, 16'h0, 16'h2222, 16'h0, 3'b000, 0, 16'h000C, 0, 16'h2222, 0, 16'h0);
    step(0, 3'b010, 3'b010, 16'h0, 16'h2222, 16'h0, 3'b010, 0, 16'h000C, 1, 16'h2222, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h0, 16'h2222, 16'h0, 3'b000, 0, 16'h000C, 0, 16'h2222, 0, 16'h0);
    // Reset while a grant is showing, then requester 1 finishes
    step(0, 3'b011, 3'b000, 16'h3333, 16'h4444, 16'h0, 3'b001, 1, 16'h3333, 0, 16'h2222, 0, 16'h0);
    step(1, 3'b010, 3'b000, 16'h3333, 16'h4444, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 1, 16'h0);
    step(0, 3'b010, 3'b000, 16'h3333, 16'h4444, 16'h0, 3'b010, 1, 16'h4444, 0, 16'h0, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h3333, 16'h4444, 16'h0, 3'b000, 0, 16'h4444, 0, 16'h0, 1, 16'h4444);
    // ptr_a now 2: requester 0 beats requester 1
    step(0, 3'b011, 3'b000, 16'h5555, 16'h6666, 16'h0, 3'b001, 1, 16'h5555, 0, 16'h0, 0, 16'h0);
    step(0, 3'b010, 3'b000, 16'h5555, 16'h6666, 16'h0, 3'b010, 1, 16'h6666, 0, 16'h0, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h5555, 16'h6666, 16'h0, 3'b000, 0, 16'h6666, 0, 16'h0, 1, 16'h6666);
    // Three-way contention on ACC_B from ptr_b = 0
    step(0, 3'b111, 3'b111, 16'h0007, 16'h0008, 16'h0009, 3'b001, 0, 16'h6666, 1, 16'h0007, 0, 16'h0);
    step(0, 3'b111, 3'b111, 16'h0007, 16'h0008, 16'h0009, 3'b010, 0, 16'h6666, 1, 16'h0008, 0, 16'h0);
    step(0, 3'b111, 3'b111, 16'h0007, 16'h0008, 16'h0009, 3'b100, 0, 16'h6666, 1, 16'h0009, 0, 16'h0);
    step(0, 3'b000, 3'b000, 16'h0007, 16'h0008, 16'h0009, 3'b000, 0, 16'h6666, 0, 16'h0009, 1, 16'h6666);
    repeat (3) @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
